note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameters SHALL be: BASE_TICK, default 12_500_000, clock cycles per tempo tick at tempo_sel=0; GAP_TICKS, default 1, silent ticks between notes; ROM_DEPTH, default 64, number of melody entries (power of two).
REQ-002 clk  in  1  system clock (50 MHz); one clock domain.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins playback from entry 0.
REQ-005 stop  in  1  one-cycle pulse that aborts playback and returns to IDLE.
REQ-006 pause  in  1  level signal; while high, playback freezes and the output is muted.
REQ-007 loop_en  in  1  level signal; when high, the end-of-song marker restarts playback at entry 0.
REQ-008 tempo_sel  in  2  selects the tick period: BASE_TICK >> tempo_sel cycles.
REQ-009 freq  out  20  note frequency in Hz, fed to the square-wave generator.
REQ-010 mute  out  1  when high, the audio path SHALL output silence.
REQ-011 note_idx  out  log2(ROM_DEPTH)  current melody address.
REQ-012 busy  out  1  high in every state except IDLE and DONE.
REQ-013 done  out  1  one-cycle pulse at non-looping song end.

Function
REQ-014 States SHALL be IDLE, LOAD, PLAY, GAP and DONE.
REQ-015 ROM entry format: {freq[19:0], dur[7:0]}; dur=0 marks end of song; freq=0 marks a rest.
REQ-016 IDLE/DONE with start=1: next state LOAD, note_idx<=0.
REQ-017 LOAD lasts exactly 1 cycle; the combinational ROM read is captured at the end of LOAD.
REQ-018 LOAD with dur!=0 and freq!=0: freq<=entry freq, mute<=0, then PLAY; freq is valid 2 edges after the start edge.
REQ-019 LOAD with freq=0 (rest): freq holds its previous value (never drives 0 downstream), mute<=1, then PLAY.
REQ-020 LOAD with dur=0 and loop_en=1: note_idx<=0, stay in LOAD; with loop_en=0: next state DONE, done=1 for that transition cycle only, mute<=1.
REQ-021 Tick counter: cleared on entry to PLAY or GAP; pulses once every (BASE_TICK>>tempo_sel) cycles; a tempo_sel change takes effect at the next counter reload.
REQ-022 PLAY: after dur ticks, mute<=1 and next state GAP.
REQ-023 GAP: after GAP_TICKS ticks, note_idx<=note_idx+1 and next state LOAD; wraps ROM_DEPTH-1 -> 0.
REQ-024 pause=1 in PLAY/GAP: cycle and tick counters freeze and mute=1; on release, mute returns to its pre-pause value and counting resumes without losing ticks.
REQ-025 pause has no effect in IDLE, LOAD or DONE.
REQ-026 stop=1 in any state: next state IDLE, mute<=1, note_idx<=0; stop beats a simultaneous start or pause.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 Reset values: state IDLE, freq=20'd440, mute=1, note_idx=0, busy=0, done=0, all counters 0.
REQ-029 Reset mid-note SHALL take effect immediately and asynchronously; the first start after deassertion plays from entry 0.

Structure
REQ-030 Package tetris_audio_pkg SHALL hold the state enum, the note_entry_t struct {freq, dur}, CLK_HZ=50_000_000 and FREQ_W=20.
REQ-031 The melody table SHALL be a sub-module melody_rom (combinational, addr -> note_entry_t); the tick divider stays inline.

Verification (BASE_TICK=8, GAP_TICKS=1, ROM={440,2},{0,1},{660,1},{0,0})
REQ-032 start at cycle 0 -> freq=440 and mute=0 after 2 edges; mute=1 after 16 cycles; 8-cycle gap; note_idx=1.
REQ-033 Rest entry -> freq stays 440 and mute=1 for 8 cycles; entry 2 then drives freq=660 with mute=0.
REQ-034 End marker with loop_en=0 -> done pulses for exactly 1 cycle, state DONE, busy=0; with loop_en=1 -> note_idx=0 and freq=440 again.
REQ-035 pause held for 20 cycles mid-PLAY -> mute=1 and freq unchanged; after release, the note completes the remaining ticks, for a total of 16 unpaused cycles.
REQ-036 stop and start in the same cycle while in PLAY -> IDLE, mute=1, note_idx=0; tempo_sel=2 -> tick period of 2 cycles.
REQ-037 reset asserted mid-PLAY between edges -> outputs reach their reset values before the next edge.

Source files
------------

// File: rtl/tetris_audio_pkg.sv
// Purpose: shared types and constants for the melody sequencer and its note ROM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_t (sequencer FSM states), note_entry_t {freq, dur}, CLK_HZ, FREQ_W, DUR_W.
package tetris_audio_pkg;

  localparam int CLK_HZ = 50_000_000;
  localparam int FREQ_W = 20;
  localparam int DUR_W  = 8;

  // Frequency driven after reset so the square-wave generator never sees 0 Hz.
  localparam logic [FREQ_W-1:0] FREQ_RESET = 20'd440;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  // dur == 0 marks end of song; freq == 0 marks a rest.
  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_entry_t;

endpackage

// File: rtl/melody_rom.sv
// Purpose: melody table, one note_entry_t per address.
// Latency: combinational (addr -> entry in the same cycle).
// Backpressure: none; always readable.
// Ports: addr (melody address), entry ({freq, dur} at that address).
module melody_rom
  import tetris_audio_pkg::*;
#(
  parameter int ROM_DEPTH = 64
) (
  input  logic [$clog2(ROM_DEPTH)-1:0] addr,
  output note_entry_t                  entry
);

  localparam int AW = $clog2(ROM_DEPTH);

  // Bring-up melody: A4 for two ticks, a one-tick rest, E5 for one tick, end.
  // Every unlisted address reads as the end-of-song marker.
  always_comb begin
    entry = '{freq: '0, dur: '0};
    case (addr)
      AW'(0):  entry = '{freq: 20'd440, dur: 8'd2};
      AW'(1):  entry = '{freq: 20'd0,   dur: 8'd1};
      AW'(2):  entry = '{freq: 20'd660, dur: 8'd1};
      default: entry = '{freq: '0, dur: '0};
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Purpose: steps through melody_rom, driving note frequency and mute to the square-wave generator.
// Latency: first note frequency/unmute 2 edges after start is sampled; note length dur ticks, then GAP_TICKS silent ticks.
// Backpressure: none; pause freezes the tick counters and mutes, stop aborts to IDLE.
// Ports: clk, reset (async, active-high), start/stop (pulses), pause/loop_en (levels),
//        tempo_sel (tick = BASE_TICK >> tempo_sel cycles), freq, mute, note_idx, busy, done (1-cycle pulse).
// GAP_TICKS must be at least 1; BASE_TICK >> 3 must be at least 1.
module note_sequencer
  import tetris_audio_pkg::*;
#(
  parameter int BASE_TICK = 12_500_000,
  parameter int GAP_TICKS = 1,
  parameter int ROM_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  input  logic                         loop_en,
  input  logic [1:0]                   tempo_sel,
  output logic [FREQ_W-1:0]            freq,
  output logic                         mute,
  output logic [$clog2(ROM_DEPTH)-1:0] note_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(ROM_DEPTH);
  localparam int CNT_W = $clog2(BASE_TICK + 1);

  state_t             state_q, state_n;
  logic [FREQ_W-1:0]  freq_q, freq_n;
  logic               mute_q, mute_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               done_q, done_n;
  logic [DUR_W-1:0]   dur_q, dur_n;
  logic [DUR_W-1:0]   tick_q, tick_n, tick_inc;
  logic [CNT_W-1:0]   cyc_q, cyc_n;
  logic [CNT_W-1:0]   period_q, period_n, reload_period;
  logic               active;
  logic               tick;
  note_entry_t        entry;

  melody_rom #(.ROM_DEPTH(ROM_DEPTH)) u_rom (
    .addr  (idx_q),
    .entry (entry)
  );

  // The tick period is latched only when the cycle counter reloads, so a
  // tempo change never produces a truncated or stretched tick mid-count.
  assign reload_period = CNT_W'(BASE_TICK >> tempo_sel);

  assign active   = (state_q == S_PLAY) || (state_q == S_GAP);
  assign tick     = active && !pause && (cyc_q == period_q - 1'b1);
  assign tick_inc = tick_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      freq_q   <= FREQ_RESET;
      mute_q   <= 1'b1;
      idx_q    <= '0;
      done_q   <= 1'b0;
      dur_q    <= '0;
      tick_q   <= '0;
      cyc_q    <= '0;
      period_q <= CNT_W'(BASE_TICK);
    end else begin
      state_q  <= state_n;
      freq_q   <= freq_n;
      mute_q   <= mute_n;
      idx_q    <= idx_n;
      done_q   <= done_n;
      dur_q    <= dur_n;
      tick_q   <= tick_n;
      cyc_q    <= cyc_n;
      period_q <= period_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    freq_n   = freq_q;
    mute_n   = mute_q;
    idx_n    = idx_q;
    done_n   = 1'b0;
    dur_n    = dur_q;
    tick_n   = tick_q;
    cyc_n    = cyc_q;
    period_n = period_q;

    // Tick divider: runs only in PLAY/GAP and holds its count while paused.
    if (active && !pause) begin
      if (tick) begin
        cyc_n    = '0;
        period_n = reload_period;
        tick_n   = tick_inc;
      end else begin
        cyc_n = cyc_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_LOAD;
          idx_n   = '0;
        end
      end
      S_LOAD: begin
        if (entry.dur == '0) begin
          if (loop_en) begin
            idx_n = '0;
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
            mute_n  = 1'b1;
          end
        end else begin
          // A rest keeps the last frequency so the generator never sees 0 Hz.
          if (entry.freq != '0) begin
            freq_n = entry.freq;
            mute_n = 1'b0;
          end else begin
            mute_n = 1'b1;
          end
          dur_n    = entry.dur;
          state_n  = S_PLAY;
          cyc_n    = '0;
          tick_n   = '0;
          period_n = reload_period;
        end
      end
      S_PLAY: begin
        if (tick && (tick_inc == dur_q)) begin
          mute_n  = 1'b1;
          state_n = S_GAP;
          cyc_n   = '0;
          tick_n  = '0;
        end
      end
      S_GAP: begin
        if (tick && (tick_inc == DUR_W'(GAP_TICKS))) begin
          idx_n   = idx_q + 1'b1;
          state_n = S_LOAD;
          cyc_n   = '0;
          tick_n  = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // stop overrides everything, including a same-cycle start or pause.
    if (stop) begin
      state_n = S_IDLE;
      mute_n  = 1'b1;
      idx_n   = '0;
      done_n  = 1'b0;
      cyc_n   = '0;
      tick_n  = '0;
    end
  end

  // Pause mutes without touching mute_q, so release restores the pre-pause value.
  assign mute     = mute_q | (active & pause);
  assign freq     = freq_q;
  assign note_idx = idx_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic [1:0]  tempo_sel;
  logic [19:0] freq;
  logic        mute;
  logic [5:0]  note_idx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          edge_n;
    logic        start;
    logic [19:0] freq;
    logic        mute;
    logic [5:0]  idx;
    logic        busy;
    logic        done;
    string       name;
  } vec_t;

  vec_t tab[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  note_sequencer #(
    .BASE_TICK (8),
    .GAP_TICKS (1),
    .ROM_DEPTH (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .tempo_sel (tempo_sel),
    .freq      (freq),
    .mute      (mute),
    .note_idx  (note_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] f, input logic m,
                       input logic [5:0] i, input logic b, input logic d);
    tests++;
    if (freq !== f || mute !== m || note_idx !== i || busy !== b || done !== d) begin
      fails++;
      $display("FAIL %s: got freq=%0d mute=%0b idx=%0d busy=%0b done=%0b, want freq=%0d mute=%0b idx=%0d busy=%0b done=%0b",
               name, freq, mute, note_idx, busy, done, f, m, i, b, d);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int e, input logic s, input logic [19:0] f, input logic m,
                              input logic [5:0] i, input logic b, input logic d, input string n);
    vec_t v;
    v.edge_n = e; v.start = s; v.freq = f; v.mute = m;
    v.idx = i; v.busy = b; v.done = d; v.name = n;
    tab.push_back(v);
  endfunction

  // Edges are counted from the edge that samples the first start of the table.
  task automatic run_table();
    int   cyc;
    vec_t v;
    cyc = 0;
    foreach (tab[k]) sb.push_back(tab[k]);
    tab.delete();
    while (sb.size() != 0) begin
      v = sb.pop_front();
      while (cyc < v.edge_n - 1) begin
        step();
        cyc++;
      end
      start = v.start;
      step();
      cyc++;
      start = 1'b0;
      check(v.name, v.freq, v.mute, v.idx, v.busy, v.done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int on_cnt;
    int guard;

    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    loop_en = 1'b0; tempo_sel = 2'd0;
    repeat (3) step();
    check("reset_state", 20'd440, 1'b1, 6'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();

    // Full song, no looping; a second start at edge 10 must be ignored.
    add(1,  1'b1, 20'd440, 1'b1, 6'd0, 1'b1, 1'b0, "song_load0");
    add(2,  1'b0, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "song_play0_first");
    add(10, 1'b1, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "song_start_while_busy");
    add(17, 1'b0, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "song_play0_last");
    add(18, 1'b0, 20'd440, 1'b1, 6'd0, 1'b1, 1'b0, "song_gap0_first");
    add(25, 1'b0, 20'd440, 1'b1, 6'd0, 1'b1, 1'b0, "song_gap0_last");
    add(26, 1'b0, 20'd440, 1'b1, 6'd1, 1'b1, 1'b0, "song_load1");
    add(27, 1'b0, 20'd440, 1'b1, 6'd1, 1'b1, 1'b0, "song_rest_first");
    add(34, 1'b0, 20'd440, 1'b1, 6'd1, 1'b1, 1'b0, "song_rest_last");
    add(43, 1'b0, 20'd440, 1'b1, 6'd2, 1'b1, 1'b0, "song_load2");
    add(44, 1'b0, 20'd660, 1'b0, 6'd2, 1'b1, 1'b0, "song_play2_first");
    add(51, 1'b0, 20'd660, 1'b0, 6'd2, 1'b1, 1'b0, "song_play2_last");
    add(52, 1'b0, 20'd660, 1'b1, 6'd2, 1'b1, 1'b0, "song_gap2");
    add(60, 1'b0, 20'd660, 1'b1, 6'd3, 1'b1, 1'b0, "song_load3");
    add(61, 1'b0, 20'd660, 1'b1, 6'd3, 1'b0, 1'b1, "song_done_pulse");
    add(62, 1'b0, 20'd660, 1'b1, 6'd3, 1'b0, 1'b0, "song_done_after");
    run_table();

    // Restart from DONE with looping enabled.
    loop_en = 1'b1;
    add(1,  1'b1, 20'd660, 1'b1, 6'd0, 1'b1, 1'b0, "loop_load0");
    add(2,  1'b0, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "loop_play0");
    add(60, 1'b0, 20'd660, 1'b1, 6'd3, 1'b1, 1'b0, "loop_load3");
    add(61, 1'b0, 20'd660, 1'b1, 6'd0, 1'b1, 1'b0, "loop_wrap");
    add(62, 1'b0, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "loop_replay0");
    run_table();
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    check("loop_stop", 20'd440, 1'b1, 6'd0, 1'b0, 1'b0);

    // Pause for 20 cycles in the middle of the first note.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pause_pre", 20'd440, 1'b0, 6'd0, 1'b1, 1'b0);
    on_cnt = 1;
    repeat (2) begin
      step();
      if (!mute) on_cnt++;
    end
    step();
    pause = 1'b1;
    #1;
    check("pause_mute", 20'd440, 1'b1, 6'd0, 1'b1, 1'b0);
    repeat (19) step();
    check("pause_hold", 20'd440, 1'b1, 6'd0, 1'b1, 1'b0);
    step();
    pause = 1'b0;
    #1;
    guard = 0;
    while (!mute && guard < 40) begin
      on_cnt++;
      step();
      guard++;
    end
    check_int("pause_unpaused_cycles", on_cnt, 16);
    check("pause_note_end", 20'd440, 1'b1, 6'd0, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // stop, start and pause together while playing entry 2.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (43) step();
    check("stop_pre", 20'd660, 1'b0, 6'd2, 1'b1, 1'b0);
    stop = 1'b1; start = 1'b1; pause = 1'b1;
    step();
    stop = 1'b0; start = 1'b0; pause = 1'b0;
    check("stop_beats_start", 20'd660, 1'b1, 6'd0, 1'b0, 1'b0);
    step();
    check("stop_stays_idle", 20'd660, 1'b1, 6'd0, 1'b0, 1'b0);

    // tempo_sel = 2: two-cycle ticks.
    tempo_sel = 2'd2;
    add(1, 1'b1, 20'd660, 1'b1, 6'd0, 1'b1, 1'b0, "tempo_load0");
    add(2, 1'b0, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "tempo_play_first");
    add(5, 1'b0, 20'd440, 1'b0, 6'd0, 1'b1, 1'b0, "tempo_play_last");
    add(6, 1'b0, 20'd440, 1'b1, 6'd0, 1'b1, 1'b0, "tempo_gap");
    add(8, 1'b0, 20'd440, 1'b1, 6'd1, 1'b1, 1'b0, "tempo_load1");
    run_table();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tempo_sel = 2'd0;

    // Asynchronous reset in the middle of entry 2, then a clean restart.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (43) step();
    check("reset_pre", 20'd660, 1'b0, 6'd2, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    check("reset_async", 20'd440, 1'b1, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("reset_restart", 20'd440, 1'b0, 6'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
